// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: datapath widths, register index types,
// architecturally named register indices and the stack pointer reset value.
package riscv_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef logic [DATA_WIDTH-1:0]     word_t;
  typedef logic [REG_ADDR_WIDTH-1:0] reg_idx_t;

  // Hard-wired zero register and ABI stack pointer
  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_SP   = 5'd2;

  // Top of the data memory, word aligned; loaded into x2 on reset
  localparam word_t SP_INIT = 32'h0000_3FFC;

endpackage

// File: rtl/register_file.sv
// Integer register file for the RV32I monocycle core.
// 31 stored registers (x1..x31); x0 is not stored and reads as zero.
// Two combinational read ports feed the ALU operands, one combinational
// debug read port, and a single write port captured on the rising edge.
// Reads are deliberately unbypassed: the write data is a function of the
// read data in a monocycle core, so a bypass would close a combinational loop.
module register_file #(
  parameter int                    DATA_WIDTH = riscv_pkg::DATA_WIDTH,
  parameter int                    ADDR_WIDTH = riscv_pkg::REG_ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] SP_INIT    = riscv_pkg::SP_INIT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr1_i,
  input  logic [ADDR_WIDTH-1:0] raddr2_i,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic [DATA_WIDTH-1:0] rdata2_o,
  input  logic [ADDR_WIDTH-1:0] dbg_addr_i,
  output logic [DATA_WIDTH-1:0] dbg_data_o
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] IDX_ZERO = ADDR_WIDTH'(riscv_pkg::REG_ZERO);
  localparam int                    IDX_SP   = int'(riscv_pkg::REG_SP);

  // Architectural state; index 0 intentionally has no storage
  logic [DATA_WIDTH-1:0] regs_reg [1:NUM_REGS-1];

  // Register array update: reset (clear, x2 <= SP_INIT) wins over any write;
  // writes to x0 are dropped
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_reg[i] <= (i == IDX_SP) ? SP_INIT : '0;
      end
    end else if (we_i && (waddr_i != IDX_ZERO)) begin
      regs_reg[waddr_i] <= wdata_i;
    end
  end

  // Read muxes sit on the ALU operand path: only the x0 select, nothing else
  assign rdata1_o   = (raddr1_i   == IDX_ZERO) ? '0 : regs_reg[raddr1_i];
  assign rdata2_o   = (raddr2_i   == IDX_ZERO) ? '0 : regs_reg[raddr2_i];
  assign dbg_data_o = (dbg_addr_i == IDX_ZERO) ? '0 : regs_reg[dbg_addr_i];

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
// Inputs are driven on the falling edge; outputs are sampled #1 after the
// rising edge (or mid-cycle for the combinational read-before-edge checks).
module tb_register_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam logic [DW-1:0] SP_VAL = 32'h0000_3FFC;

  logic          clk;
  logic          rst;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] raddr1;
  logic [AW-1:0] raddr2;
  logic [DW-1:0] rdata1;
  logic [DW-1:0] rdata2;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;

  int checks   = 0;
  int failures = 0;

  // Expected architectural contents, maintained by hand from the stimulus
  logic [DW-1:0] exp_regs [32];

  register_file #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .SP_INIT    (SP_VAL)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .we_i       (we),
    .waddr_i    (waddr),
    .wdata_i    (wdata),
    .raddr1_i   (raddr1),
    .raddr2_i   (raddr2),
    .rdata1_o   (rdata1),
    .rdata2_o   (rdata2),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One write transaction: drive at falling edge, capture at rising edge
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0;
    if (a != 0) exp_regs[a] = d;
    $display("write x%0d = %h", a, d);
  endtask

  // One reset edge, optionally with a conflicting write on the same edge
  task automatic do_reset(input logic with_write, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    @(negedge clk);
    rst   = 1'b1;
    we    = with_write;
    waddr = a;
    wdata = d;
    @(posedge clk);
    #1;
    rst = 1'b0;
    we  = 1'b0;
    for (int i = 0; i < 32; i++) exp_regs[i] = '0;
    exp_regs[2] = SP_VAL;
    $display("reset (write_en=%0b x%0d = %h)", with_write, a, d);
  endtask

  // Sweep every index on the debug port against the expected image
  task automatic sweep_dbg(input string tag);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = AW'(i);
      #1;
      checks++;
      if (dbg_data !== exp_regs[i]) begin
        failures++;
        $display("FAIL %s dbg x%0d: got %h expected %h", tag, i, dbg_data, exp_regs[i]);
      end
    end
  endtask

  task automatic test_x0_before_reset();
    raddr1 = '0; raddr2 = '0; dbg_addr = '0;
    #1;
    checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0 || dbg_data !== 32'h0) begin
      failures++;
      $display("FAIL x0_pre_reset: got %h/%h/%h expected 0", rdata1, rdata2, dbg_data);
    end
    $display("read x0 before reset = %h", rdata1);
  endtask

  task automatic test_reset();
    do_reset(1'b0, '0, '0);
    sweep_dbg("reset");
    raddr1 = 5'd2; raddr2 = 5'd3;
    #1;
    checks++;
    if (rdata1 !== SP_VAL || rdata2 !== 32'h0) begin
      failures++;
      $display("FAIL reset_ports: got %h/%h expected %h/00000000", rdata1, rdata2, SP_VAL);
    end
  endtask

  task automatic test_write_read();
    do_write(5'd5, 32'h1234_5678);
    raddr1 = 5'd5; raddr2 = 5'd5;
    #1;
    checks++;
    if (rdata1 !== 32'h1234_5678 || rdata2 !== 32'h1234_5678) begin
      failures++;
      $display("FAIL write_x5: got %h/%h expected 12345678", rdata1, rdata2);
    end
    do_write(5'd6, 32'hFFFF_0000);
    raddr1 = 5'd5; raddr2 = 5'd6;
    #1;
    checks++;
    if (rdata1 !== 32'h1234_5678 || rdata2 !== 32'hFFFF_0000) begin
      failures++;
      $display("FAIL write_x6: got x5=%h x6=%h expected 12345678/ffff0000", rdata1, rdata2);
    end
  endtask

  task automatic test_x0_immutable();
    do_write(5'd0, 32'hFFFF_FFFF);
    raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      failures++;
      $display("FAIL x0_write: got %h/%h expected 0", rdata1, rdata2);
    end
    sweep_dbg("x0_write");
  endtask

  task automatic test_read_during_write();
    do_write(5'd7, 32'hAAAA_AAAA);
    @(negedge clk);
    raddr1 = 5'd7;
    we     = 1'b1;
    waddr  = 5'd7;
    wdata  = 32'h5555_5555;
    #1;
    checks++;
    if (rdata1 !== 32'hAAAA_AAAA) begin
      failures++;
      $display("FAIL rdw_before_edge: got %h expected aaaaaaaa", rdata1);
    end
    @(posedge clk);
    #1;
    we = 1'b0;
    exp_regs[7] = 32'h5555_5555;
    $display("write x7 = 55555555 (read-during-write)");
    checks++;
    if (rdata1 !== 32'h5555_5555) begin
      failures++;
      $display("FAIL rdw_after_edge: got %h expected 55555555", rdata1);
    end
  endtask

  task automatic test_we_low();
    @(negedge clk);
    we = 1'b0; waddr = 5'd9; wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    $display("idle cycle with we=0 x9 = deadbeef");
    dbg_addr = 5'd9;
    #1;
    checks++;
    if (dbg_data !== 32'h0) begin
      failures++;
      $display("FAIL we_low_x9: got %h expected 00000000", dbg_data);
    end
  endtask

  task automatic test_back_to_back();
    // Distinct value per register, one write per consecutive cycle
    @(negedge clk);
    for (int i = 1; i < 32; i++) begin
      we    = 1'b1;
      waddr = AW'(i);
      wdata = 32'hA5A5_0000 | (32'(i) << 8) | 32'(i);
      exp_regs[i] = wdata;
      @(negedge clk);
      $display("write x%0d = %h (back-to-back)", i, exp_regs[i]);
    end
    we = 1'b0;
    #1;
    sweep_dbg("b2b");
    for (int i = 0; i < 32; i++) begin
      raddr1 = AW'(i);
      raddr2 = AW'(31 - i);
      #1;
      checks++;
      if (rdata1 !== exp_regs[i] || rdata2 !== exp_regs[31 - i]) begin
        failures++;
        $display("FAIL b2b_ports x%0d/x%0d: got %h/%h expected %h/%h",
                 i, 31 - i, rdata1, rdata2, exp_regs[i], exp_regs[31 - i]);
      end
    end
  endtask

  task automatic test_reset_vs_write();
    do_reset(1'b1, 5'd2, 32'h0);
    dbg_addr = 5'd2;
    #1;
    checks++;
    if (dbg_data !== SP_VAL) begin
      failures++;
      $display("FAIL reset_vs_write_x2: got %h expected %h", dbg_data, SP_VAL);
    end
    do_write(5'd10, 32'hCAFE_F00D);
    dbg_addr = 5'd10;
    #1;
    checks++;
    if (dbg_data !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL write_x10: got %h expected cafef00d", dbg_data);
    end
    do_reset(1'b1, 5'd10, 32'h1111_1111);
    dbg_addr = 5'd10;
    #1;
    checks++;
    if (dbg_data !== 32'h0) begin
      failures++;
      $display("FAIL midreset_x10: got %h expected 00000000", dbg_data);
    end
    sweep_dbg("midreset");
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    raddr1 = '0; raddr2 = '0; dbg_addr = '0;
    for (int i = 0; i < 32; i++) exp_regs[i] = '0;

    test_x0_before_reset();
    test_reset();
    test_write_read();
    test_x0_immutable();
    test_read_during_write();
    test_we_low();
    test_back_to_back();
    test_reset_vs_write();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
